// File: rtl/efc_sfrm_ctl_if.sv
// Frame-capture bus: edge pulses and serial data in, buffered words and status out.
// The slave modport is the capture controller; the master modport is its environment.
interface efc_sfrm_ctl_if #(
    parameter int WIDTH = 32
);
    logic             sclk_rise;
    logic             sdata_sync;
    logic             frame_rise;
    logic             frame_fall;
    logic [WIDTH-1:0] word_data;
    logic             word_vld;
    logic             word_rdy;
    logic             busy;
    logic             err_bitcnt;
    logic             err_ovf;
    logic             err_tmo;

    modport master (
        output sclk_rise, sdata_sync, frame_rise, frame_fall, word_rdy,
        input  word_data, word_vld, busy, err_bitcnt, err_ovf, err_tmo
    );

    modport slave (
        input  sclk_rise, sdata_sync, frame_rise, frame_fall, word_rdy,
        output word_data, word_vld, busy, err_bitcnt, err_ovf, err_tmo
    );
endinterface

// File: rtl/efc_sfrm_ctl.sv
// Serial-frame capture controller: shifts framed serial bits into WIDTH-bit words
// and queues them in a 2-entry valid/ready buffer, flagging malformed/stalled frames.
module efc_sfrm_ctl #(
    parameter int WIDTH = 32,
    parameter int TMO   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    efc_sfrm_ctl_if.slave      bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CW-1:0]    bitcnt_r, bitcnt_nxt_s;
    logic [TW-1:0]    timer_r, timer_nxt_s;
    logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
    logic             excess_r, excess_nxt_s;
    logic             push_s, err_bitcnt_s, err_ovf_s, err_tmo_s;
    logic             pop_s, full_s;
    logic [WIDTH-1:0] slot0_r, slot1_r;
    logic [1:0]       count_r;
    logic             busy_r, err_bitcnt_r, err_ovf_r, err_tmo_r;

    assign pop_s  = (count_r != 2'd0) && bus.word_rdy;
    assign full_s = (count_r == 2'd2);

    // Next-state, frame assembly and error/push decisions
    always_comb begin
        state_nxt_s  = state_r;
        bitcnt_nxt_s = bitcnt_r;
        timer_nxt_s  = timer_r;
        shreg_nxt_s  = shreg_r;
        excess_nxt_s = excess_r;
        push_s       = 1'b0;
        err_bitcnt_s = 1'b0;
        err_ovf_s    = 1'b0;
        err_tmo_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.frame_rise) begin
                    state_nxt_s  = ST_SHIFT;
                    bitcnt_nxt_s = '0;
                    timer_nxt_s  = '0;
                    excess_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.sclk_rise) begin
                    shreg_nxt_s = {shreg_r[WIDTH-2:0], bus.sdata_sync};
                    timer_nxt_s = '0;
                    if (bitcnt_r < FULL_CNT) begin
                        bitcnt_nxt_s = bitcnt_r + CW'(1);
                    end else begin
                        excess_nxt_s = 1'b1;
                    end
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
                // Frame end wins over a coincident timeout and sees this cycle's bit
                if (bus.frame_fall) begin
                    state_nxt_s = ST_IDLE;
                    if ((bitcnt_nxt_s == FULL_CNT) && !excess_nxt_s) begin
                        if (!full_s || pop_s) begin
                            push_s = 1'b1;
                        end else begin
                            err_ovf_s = 1'b1;
                        end
                    end else begin
                        err_bitcnt_s = 1'b1;
                    end
                end else if (!bus.sclk_rise && (timer_r == TMO_LAST)) begin
                    state_nxt_s = ST_DRAIN;
                    err_tmo_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DRAIN: begin
                if (bus.frame_fall) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control state, shift register and registered status/error outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bitcnt_r     <= '0;
            timer_r      <= '0;
            shreg_r      <= '0;
            excess_r     <= 1'b0;
            busy_r       <= 1'b0;
            err_bitcnt_r <= 1'b0;
            err_ovf_r    <= 1'b0;
            err_tmo_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            bitcnt_r     <= bitcnt_nxt_s;
            timer_r      <= timer_nxt_s;
            shreg_r      <= shreg_nxt_s;
            excess_r     <= excess_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            err_bitcnt_r <= err_bitcnt_s;
            err_ovf_r    <= err_ovf_s;
            err_tmo_r    <= err_tmo_s;
        end
    end

    // Two-entry output buffer; slot0 is always the presented head word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_r <= '0;
            slot1_r <= '0;
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_r <= shreg_nxt_s;
                        count_r <= 2'd1;
                    end else begin
                        slot1_r <= shreg_nxt_s;
                        count_r <= 2'd2;
                    end
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        slot0_r <= shreg_nxt_s;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= shreg_nxt_s;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign bus.word_data  = slot0_r;
    assign bus.word_vld   = (count_r != 2'd0);
    assign bus.busy       = busy_r;
    assign bus.err_bitcnt = err_bitcnt_r;
    assign bus.err_ovf    = err_ovf_r;
    assign bus.err_tmo    = err_tmo_r;
endmodule

// File: tb/tb_efc_sfrm_ctl.sv
// Self-checking bench for efc_sfrm_ctl (WIDTH=32, TMO=16): directed scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_efc_sfrm_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int n_bitcnt = 0, n_ovf = 0, n_tmo = 0;

    efc_sfrm_ctl_if #(.WIDTH(32)) bus ();
    efc_sfrm_ctl #(.WIDTH(32), .TMO(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Mid-cycle monitor: delivered words and error high-cycles
    always @(negedge clk) begin
        if (bus.word_vld && bus.word_rdy) got_q.push_back(bus.word_data);
        if (bus.err_bitcnt) n_bitcnt++;
        if (bus.err_ovf) n_ovf++;
        if (bus.err_tmo) n_tmo++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits, input bit coincide,
                              input int gap_max, input bit rdy_on_fall);
        bus.frame_rise = 1'b1;
        tick;
        bus.frame_rise = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.sclk_rise  = 1'b1;
            bus.sdata_sync = (i < 32) ? data[31-i] : 1'($urandom);
            if (coincide && i == nbits - 1) begin
                bus.frame_fall = 1'b1;
                if (rdy_on_fall) bus.word_rdy = 1'b1;
            end
            tick;
            bus.sclk_rise  = 1'b0;
            bus.sdata_sync = 1'b0;
            if (!(coincide && i == nbits - 1)) repeat ($urandom_range(gap_max, 0)) tick;
        end
        if (!coincide) begin
            bus.frame_fall = 1'b1;
            if (rdy_on_fall) bus.word_rdy = 1'b1;
            tick;
        end
        bus.frame_fall = 1'b0;
        if (rdy_on_fall) bus.word_rdy = 1'b0;
    endtask

    task automatic test_reset;
        bus.sclk_rise = 1'b0; bus.sdata_sync = 1'b0; bus.frame_rise = 1'b0;
        bus.frame_fall = 1'b0; bus.word_rdy = 1'b0;
        rst = 1'b1;
        repeat (3) tick;
        total++; if (bus.word_vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got %0b want 0", bus.word_vld); end
        total++; if (bus.word_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.word_data); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        total++; if ({bus.err_bitcnt, bus.err_ovf, bus.err_tmo} !== 3'b000) begin
            bad++; $display("FAIL rst_err: got %b want 000", {bus.err_bitcnt, bus.err_ovf, bus.err_tmo}); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_good_frame;
        got_q.delete();
        bus.frame_rise = 1'b1;
        tick;
        bus.frame_rise = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_rise: got %0b want 1", bus.busy); end
        send_frame(32'hA5C3_0F1E, 32, 1'b0, 0, 1'b0);
        total++; if (bus.word_vld !== 1'b1) begin bad++; $display("FAIL good_vld: got %0b want 1", bus.word_vld); end
        total++; if (bus.word_data !== 32'hA5C3_0F1E) begin bad++; $display("FAIL good_data: got %h want a5c30f1e", bus.word_data); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL good_busy: got %0b want 0", bus.busy); end
        total++; if ({bus.err_bitcnt, bus.err_ovf, bus.err_tmo} !== 3'b000) begin
            bad++; $display("FAIL good_err: got %b want 000", {bus.err_bitcnt, bus.err_ovf, bus.err_tmo}); end
        bus.word_rdy = 1'b1;
        tick;
        bus.word_rdy = 1'b0;
        total++; if (bus.word_vld !== 1'b0) begin bad++; $display("FAIL good_pop: got %0b want 0", bus.word_vld); end
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL good_count: got %0d want 1", got_q.size()); end
    endtask

    task automatic test_bitcnt;
        int nb[2] = '{31, 33};
        foreach (nb[k]) begin
            send_frame($urandom, nb[k], 1'b0, 1, 1'b0);
            total++; if (bus.err_bitcnt !== 1'b1) begin bad++; $display("FAIL bitcnt_%0d: got %0b want 1", nb[k], bus.err_bitcnt); end
            tick;
            total++; if (bus.err_bitcnt !== 1'b0) begin bad++; $display("FAIL bitcnt_pulse_%0d: got %0b want 0", nb[k], bus.err_bitcnt); end
            total++; if (bus.word_vld !== 1'b0) begin bad++; $display("FAIL bitcnt_vld_%0d: got %0b want 0", nb[k], bus.word_vld); end
        end
        send_frame(32'h1357_9BDF, 32, 1'b1, 1, 1'b0);
        total++; if (bus.err_bitcnt !== 1'b0) begin bad++; $display("FAIL coincide_err: got %0b want 0", bus.err_bitcnt); end
        total++; if (bus.word_data !== 32'h1357_9BDF || bus.word_vld !== 1'b1) begin
            bad++; $display("FAIL coincide_word: got %h/%0b want 13579bdf/1", bus.word_data, bus.word_vld); end
        bus.word_rdy = 1'b1;
        tick;
        bus.word_rdy = 1'b0;
    endtask

    task automatic test_overflow;
        got_q.delete();
        send_frame(32'h1, 32, 1'b0, 0, 1'b0);
        send_frame(32'h2, 32, 1'b0, 0, 1'b0);
        send_frame(32'h3, 32, 1'b0, 0, 1'b0);
        total++; if (bus.err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %0b want 1", bus.err_ovf); end
        total++; if (bus.word_data !== 32'h1) begin bad++; $display("FAIL ovf_head: got %h want 1", bus.word_data); end
        tick;
        total++; if (bus.err_ovf !== 1'b0) begin bad++; $display("FAIL ovf_width: got %0b want 0", bus.err_ovf); end
        bus.word_rdy = 1'b1;
        repeat (4) tick;
        bus.word_rdy = 1'b0;
        total++; if (got_q.size() != 2 || got_q[0] !== 32'h1 || got_q[1] !== 32'h2) begin
            bad++; $display("FAIL ovf_drain: got %0d words want 1,2", got_q.size()); end
        total++; if (bus.word_vld !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %0b want 0", bus.word_vld); end
        got_q.delete();
        send_frame(32'h1, 32, 1'b0, 0, 1'b0);
        send_frame(32'h2, 32, 1'b0, 0, 1'b0);
        send_frame(32'h3, 32, 1'b0, 0, 1'b1);
        total++; if (bus.err_ovf !== 1'b0) begin bad++; $display("FAIL ovf_pop_push: got %0b want 0", bus.err_ovf); end
        bus.word_rdy = 1'b1;
        repeat (4) tick;
        bus.word_rdy = 1'b0;
        total++; if (got_q.size() != 3 || got_q[0] !== 32'h1 || got_q[1] !== 32'h2 || got_q[2] !== 32'h3) begin
            bad++; $display("FAIL ovf_retain: got %0d words want 1,2,3", got_q.size()); end
    endtask

    task automatic test_timeout;
        int t0 = n_tmo;
        int b0 = n_bitcnt;
        bus.frame_rise = 1'b1;
        tick;
        bus.frame_rise = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.sclk_rise = 1'b1; bus.sdata_sync = 1'($urandom);
            tick;
            bus.sclk_rise = 1'b0;
        end
        repeat (15) tick;
        total++; if (bus.err_tmo !== 1'b0) begin bad++; $display("FAIL tmo_early: got %0b want 0", bus.err_tmo); end
        tick;
        total++; if (bus.err_tmo !== 1'b1) begin bad++; $display("FAIL tmo_pulse: got %0b want 1", bus.err_tmo); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL tmo_busy: got %0b want 1", bus.busy); end
        for (int i = 0; i < 3; i++) begin
            bus.sclk_rise = 1'b1;
            tick;
            bus.sclk_rise = 1'b0;
        end
        repeat (20) tick;
        total++; if (n_tmo - t0 != 1) begin bad++; $display("FAIL tmo_once: got %0d want 1", n_tmo - t0); end
        bus.frame_fall = 1'b1;
        tick;
        bus.frame_fall = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL tmo_idle: got %0b want 0", bus.busy); end
        tick;
        total++; if (n_bitcnt != b0 || bus.word_vld !== 1'b0) begin
            bad++; $display("FAIL tmo_end: got bitcnt_err=%0d vld=%0b want 0/0", n_bitcnt - b0, bus.word_vld); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] w;
        int e0;
        send_frame($urandom, 32, 1'b0, 0, 1'b0);
        bus.frame_rise = 1'b1;
        tick;
        bus.frame_rise = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.sclk_rise = 1'b1; bus.sdata_sync = 1'($urandom);
            tick;
            bus.sclk_rise = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.word_vld !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid: got vld=%0b busy=%0b want 0/0", bus.word_vld, bus.busy); end
        tick;
        rst = 1'b0;
        e0 = n_bitcnt + n_ovf + n_tmo;
        got_q.delete();
        w = $urandom;
        send_frame(w, 32, 1'b0, 2, 1'b0);
        bus.word_rdy = 1'b1;
        repeat (3) tick;
        bus.word_rdy = 1'b0;
        total++; if (got_q.size() != 1 || got_q[0] !== w) begin
            bad++; $display("FAIL rst_after: got %0d words want exactly %h", got_q.size(), w); end
        total++; if (n_bitcnt + n_ovf + n_tmo != e0) begin bad++; $display("FAIL rst_noerr: got %0d want 0", n_bitcnt + n_ovf + n_tmo - e0); end
    endtask

    task automatic test_back_to_back;
        int e0 = n_bitcnt + n_ovf + n_tmo;
        got_q.delete();
        bus.word_rdy = 1'b1;
        send_frame(32'hFFFF_FFFF, 32, 1'b0, 0, 1'b0);
        send_frame(32'h0000_0001, 32, 1'b0, 0, 1'b0);
        repeat (3) tick;
        bus.word_rdy = 1'b0;
        total++; if (got_q.size() != 2 || got_q[0] !== 32'hFFFF_FFFF || got_q[1] !== 32'h1) begin
            bad++; $display("FAIL b2b_words: got %0d words want ffffffff,00000001", got_q.size()); end
        total++; if (n_bitcnt + n_ovf + n_tmo != e0) begin bad++; $display("FAIL b2b_err: got %0d want 0", n_bitcnt + n_ovf + n_tmo - e0); end
    endtask

    task automatic test_random;
        int b0 = n_bitcnt;
        int o0 = n_ovf;
        int exp_bad = 0;
        got_q.delete();
        exp_q.delete();
        bus.word_rdy = 1'b1;
        for (int f = 0; f < 24; f++) begin
            logic [31:0] d = $urandom;
            int nb = ($urandom_range(1, 0) == 0) ? 32 : int'($urandom_range(34, 30));
            // Reference: a frame is good exactly when it carried WIDTH bits
            if (nb == 32) exp_q.push_back(d);
            else exp_bad++;
            send_frame(d, nb, 1'($urandom), 3, 1'b0);
            repeat ($urandom_range(2, 0)) tick;
        end
        repeat (3) tick;
        bus.word_rdy = 1'b0;
        total++; if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (n_bitcnt - b0 != exp_bad) begin bad++; $display("FAIL rnd_bitcnt: got %0d want %0d", n_bitcnt - b0, exp_bad); end
        total++; if (n_ovf != o0) begin bad++; $display("FAIL rnd_ovf: got %0d want 0", n_ovf - o0); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bitcnt;
        test_overflow;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
